// File: rtl/apb_slave_ram_pkg.sv
// Shared types and constants for the APB4 completer RAM: FSM states, strobe constants and default bus widths.
package apb_slave_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_t;

    localparam logic [3:0] PSTRB_NONE = 4'b0000;
    localparam logic [3:0] PSTRB_FULL = 4'b1111;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    // Width of a down-counter that must hold the value n (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_strb_merge.sv
// Byte-lane merge: each lane of the result takes the new byte when its strobe bit is set, else keeps the old byte.
module apb_strb_merge #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] new_word,
    input  logic [STRB_WIDTH-1:0] strb,
    output logic [DATA_WIDTH-1:0] merged_word
);

    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = strb[gi] ? new_word[gi*8 +: 8] : old_word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/apb_slave_ram.sv
// APB4 completer backed by a word-addressed RAM. Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait
// states per access; without it every access completes in its first ACCESS cycle.
module apb_slave_ram
    import apb_slave_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [2:0]            PPROT,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    apb_state_t            state_reg;
    logic [IDX_WIDTH-1:0]  idx_reg;
    logic                  write_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0] strb_reg;
    logic [2:0]            prot_reg;

    logic [ADDR_WIDTH-3:0] word_idx;
    logic                  setup_phase;
    logic                  setup_err;
    logic                  cnt_zero;
    logic                  access_ready;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] merged_word;

    assign word_idx    = PADDR[ADDR_WIDTH-1:2];
    assign setup_phase = PSEL && !PENABLE;
    assign setup_err   = (64'(word_idx) >= 64'(MEM_DEPTH))
                      || (!PWRITE && (PSTRB != '0))
                      || (PADDR[1:0] != 2'b00);

`ifdef APB_SLV_WAIT_EN
    localparam int CNT_WIDTH = cnt_width(WAIT_CYCLES);
    logic [CNT_WIDTH-1:0] cnt_reg;
    assign cnt_zero = (cnt_reg == '0);
`else
    assign cnt_zero = 1'b1;
`endif

    // A dropped PSEL during ACCESS is an abort, so the ready cycle also needs PSEL.
    assign access_ready = (state_reg == ACCESS) && PSEL && cnt_zero;
    assign PREADY       = access_ready;
    assign PSLVERR      = access_ready && err_reg;
    assign mem_we       = access_ready && write_reg && !err_reg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            write_reg <= 1'b0;
            err_reg   <= 1'b0;
            wdata_reg <= '0;
            strb_reg  <= '0;
            prot_reg  <= '0;
            PRDATA    <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (setup_phase) begin
                        state_reg <= ACCESS;
                        idx_reg   <= word_idx[IDX_WIDTH-1:0];
                        write_reg <= PWRITE;
                        err_reg   <= setup_err;
                        wdata_reg <= PWDATA;
                        strb_reg  <= PSTRB;
                        prot_reg  <= PPROT;
                        if (!PWRITE) begin
                            PRDATA <= setup_err ? '0 : mem[word_idx[IDX_WIDTH-1:0]];
                        end
`ifdef APB_SLV_WAIT_EN
                        cnt_reg   <= CNT_WIDTH'(WAIT_CYCLES);
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state_reg <= IDLE;
`ifdef APB_SLV_WAIT_EN
                        cnt_reg   <= '0;
`endif
                    end else if (cnt_zero) begin
                        state_reg <= DONE;
                    end
`ifdef APB_SLV_WAIT_EN
                    else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    apb_strb_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_merge (
        .old_word    (mem[idx_reg]),
        .new_word    (wdata_reg),
        .strb        (strb_reg),
        .merged_word (merged_word)
    );

    // Memory has no reset; the write lands on the edge that ends the PREADY cycle.
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            mem[idx_reg] <= merged_word;
        end
    end

endmodule

// File: tb/tb_apb_slave_ram.sv
// Self-checking bench for apb_slave_ram: directed scenarios plus randomized traffic against a word-array model.
module tb_apb_slave_ram;
    import apb_slave_ram_pkg::*;

`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [256];
    bit          model_valid [256];
    logic [31:0] model_prdata;
    bit          model_prdata_known;

    apb_slave_ram #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (256),
        .WAIT_CYCLES (2)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PPROT   (PPROT),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    // Full APB transfer starting at posedge+1; returns at posedge+1 after the ready edge, bus still driven.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        logic [31:0] idx;
        bit          err;
        int          waits;
        int          i;
        idx = addr >> 2;
        err = (idx >= 32'd256) || (!wr && strb != PSTRB_NONE) || (addr[1:0] != 2'b00);
        i   = int'(idx[7:0]);

        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        PSTRB   = strb;
        PPROT   = 3'($urandom_range(0, 7));
        check("setup_pready_low", 32'(PREADY), 32'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        while (PREADY !== 1'b1 && waits < 20) begin
            @(posedge PCLK); #1;
            waits++;
        end
        check("wait_states", 32'(waits), 32'(EXP_WAIT));
        check("pslverr", 32'(PSLVERR), 32'(err));

        if (wr) begin
            if (!err) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model_mem[i][b*8 +: 8] = data[b*8 +: 8];
                end
                if (strb == PSTRB_FULL) model_valid[i] = 1'b1;
            end
        end else begin
            model_prdata       = err ? 32'd0 : model_mem[i];
            model_prdata_known = err || model_valid[i];
        end

        @(posedge PCLK); #1;
        check("pready_after_ready", 32'(PREADY), 32'd0);
        if (model_prdata_known) check(wr ? "prdata_hold" : "prdata", PRDATA, model_prdata);
        $display("[TB] %s addr=0x%08h data=0x%08h strb=%04b err=%0d waits=%0d prdata=0x%08h",
                 wr ? "WR" : "RD", addr, data, strb, err, waits, PRDATA);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          w;
        int          kind;

        for (int k = 0; k < 256; k++) model_valid[k] = 1'b0;
        model_prdata       = 32'd0;
        model_prdata_known = 1'b1;

        PRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = '0;
        PPROT   = '0;
        #1;
        check("reset_pready", 32'(PREADY), 32'd0);
        check("reset_pslverr", 32'(PSLVERR), 32'd0);
        check("reset_prdata", PRDATA, 32'd0);
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Preload words 0..15 so every later read has a known expected value.
        for (int k = 0; k < 16; k++) begin
            apb_xfer(1'b1, 32'(k * 4), $urandom, PSTRB_FULL);
            bus_idle();
        end

        // Full write then read back.
        apb_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, PSTRB_FULL);
        bus_idle();
        apb_xfer(1'b0, 32'h0000_0010, 32'h0, PSTRB_NONE);
        check("deadbeef_readback", PRDATA, 32'hDEAD_BEEF);
        bus_idle();

        // Partial-strobe merge.
        apb_xfer(1'b1, 32'h0000_0020, 32'h1122_3344, PSTRB_FULL);
        bus_idle();
        apb_xfer(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
        bus_idle();
        apb_xfer(1'b0, 32'h0000_0020, 32'h0, PSTRB_NONE);
        check("strb_merge", PRDATA, 32'h11BB_33DD);
        bus_idle();

        // Out-of-range index must not alias onto word 0.
        apb_xfer(1'b0, 32'h0000_0400, 32'h0, PSTRB_NONE);
        check("oor_read_zero", PRDATA, 32'd0);
        bus_idle();
        apb_xfer(1'b1, 32'h0000_0400, 32'h0BAD_0BAD, PSTRB_FULL);
        bus_idle();
        apb_xfer(1'b0, 32'h0000_0000, 32'h0, PSTRB_NONE);
        bus_idle();

        // Read with strobes, and misaligned write.
        apb_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h1);
        check("strb_read_zero", PRDATA, 32'd0);
        bus_idle();
        apb_xfer(1'b1, 32'h0000_0012, 32'h5555_5555, PSTRB_FULL);
        bus_idle();
        apb_xfer(1'b0, 32'h0000_0010, 32'h0, PSTRB_NONE);
        check("misaligned_no_write", PRDATA, 32'hDEAD_BEEF);
        bus_idle();

        // Reset in the middle of a write drops it and clears outputs at once.
        apb_xfer(1'b1, 32'h0000_0030, 32'hCAFE_F00D, PSTRB_FULL);
        bus_idle();
        apb_xfer(1'b0, 32'h0000_0030, 32'h0, PSTRB_NONE);
        bus_idle();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'h55; PSTRB = PSTRB_FULL;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (EXP_WAIT >= 2) begin
            @(posedge PCLK); #1;
        end
        PRESETn = 1'b0;
        #1;
        check("midreset_pready", 32'(PREADY), 32'd0);
        check("midreset_pslverr", 32'(PSLVERR), 32'd0);
        check("midreset_prdata", PRDATA, 32'd0);
        model_prdata = 32'd0;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        $display("[TB] RST during write addr=0x00000030 data=0x00000055");
        apb_xfer(1'b0, 32'h0000_0030, 32'h0, PSTRB_NONE);
        check("reset_dropped_write", PRDATA, 32'hCAFE_F00D);
        bus_idle();

        // Abort: PSEL drops during ACCESS.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h34; PWDATA = 32'h7777_7777; PSTRB = PSTRB_FULL;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b1;
        #1;
        check("abort_pready", 32'(PREADY), 32'd0);
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        $display("[TB] ABORT write addr=0x00000034");
        apb_xfer(1'b0, 32'h0000_0034, 32'h0, PSTRB_NONE);
        bus_idle();

        // Back-to-back writes, then read both back.
        apb_xfer(1'b1, 32'h0000_0040, 32'h0101_0101, PSTRB_FULL);
        apb_xfer(1'b1, 32'h0000_0044, 32'h0202_0202, PSTRB_FULL);
        apb_xfer(1'b0, 32'h0000_0040, 32'h0, PSTRB_NONE);
        check("b2b_word0", PRDATA, 32'h0101_0101);
        apb_xfer(1'b0, 32'h0000_0044, 32'h0, PSTRB_NONE);
        check("b2b_word1", PRDATA, 32'h0202_0202);
        bus_idle();

        // Randomized traffic, mixing idle gaps and back-to-back transfers.
        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 17)) * 4;
            if (kind == 7) a = a + 32'($urandom_range(1, 3));
            else if (kind == 8) a = 32'h400 + 32'($urandom_range(0, 63)) * 4;
            else if (kind == 9) a = $urandom;
            w = bit'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (!w && $urandom_range(0, 4) != 0) s = PSTRB_NONE;
            apb_xfer(w, a, d, s);
            if ($urandom_range(0, 1) == 0) bus_idle();
        end
        bus_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
